dmem_lsu_bank: RTL and testbench
================================

Name: dmem_lsu_bank

Overview:
- Parametrised, handshaked data-memory bank for the MEM stage of the out-of-order core.
- Generalises the single-cycle word memory with:
  - byte, half and word accesses with sign/zero extension on loads;
  - byte-lane write masking;
  - a configurable read pipeline with tagged in-order responses;
  - misalign and range error reporting;
  - a post-reset clear sweep.
- Sits between the LSU issue port and the ROB/CDB writeback arbiter.

Parameters:
- DATA_WIDTH, 32, data word width in bits; multiple of 8.
- ADDR_WIDTH, 32, byte-address width.
- DEPTH_WORDS, 1024, number of words; power of 2; $clog2(DEPTH_WORDS)+$clog2(DATA_WIDTH/8) <= ADDR_WIDTH.
- RD_LATENCY, 1, cycles from request accept to response valid; legal range 1..4.
- TAG_WIDTH, 6, width of the ROB tag carried with each request.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- req_valid_i  in  1  request valid
- req_ready_o  out  1  request ready
- req_we_i  in  1  1 = store, 0 = load
- req_addr_i  in  ADDR_WIDTH  byte address
- req_size_i  in  2  0 = byte, 1 = half, 2 = word; 3 is illegal
- req_unsigned_i  in  1  load zero-extend (LBU/LHU)
- req_wdata_i  in  DATA_WIDTH  store data, right-aligned
- req_tag_i  in  TAG_WIDTH  ROB tag
- rsp_valid_o  out  1  response valid
- rsp_ready_i  in  1  response ready
- rsp_rdata_o  out  DATA_WIDTH  extended load data; 0 for stores and errors
- rsp_tag_o  out  TAG_WIDTH  tag of the response
- rsp_err_o  out  1  misaligned, out-of-range or illegal size
- busy_o  out  1  high while in the INIT state

Behaviour:
- Reset (rst high at a posedge):
  - req_ready_o=0, rsp_valid_o=0, rsp_rdata_o=0, rsp_tag_o=0, rsp_err_o=0, busy_o=1.
  - Pipeline valids and response FIFO are cleared; in-flight requests are dropped.
  - Reset asserted mid-operation behaves identically.
- FSM states and transitions:
  - INIT: one word zeroed per cycle, index 0..DEPTH_WORDS-1. After the last index, go to RUN on the next cycle.
  - RUN: busy_o=0.
  - Reset from any state goes to INIT.
- Accept rule:
  - A request is accepted when req_valid_i && req_ready_o at a posedge.
  - req_ready_o = (state==RUN) && (outstanding < RD_LATENCY+1).
  - outstanding = requests in the pipeline + entries in the response FIFO.
- Word index = addr[$clog2(DEPTH_WORDS)+1:2]; byte offset = addr[1:0] (for DATA_WIDTH=32).
- Error conditions (checked at accept):
  - half with addr[0]=1;
  - word with addr[1:0]!=0;
  - req_size_i==3;
  - any address bit above the index field set.
  - On error: no memory write, rsp_err_o=1, rsp_rdata_o=0.
- Stores:
  - Memory is written at the accept edge.
  - Byte lanes are enabled by size and offset; data is replicated into the lanes (byte to all 4 lanes, half to both halves).
  - A response is still returned, with rdata=0.
- Loads:
  - Memory is read at the accept edge.
  - The lane is selected by offset, then sign- or zero-extended per req_unsigned_i; word loads are not extended.
- Ordering and same-cycle events:
  - Read-before-write is not a hazard: requests are strictly serialized, so a load accepted after a store to the same address returns the new data.
  - Responses appear exactly RD_LATENCY cycles after accept when the FIFO is empty and rsp_ready_i=1.
  - Responses stay in order. Under rsp_ready_i=0 they queue in a FIFO of depth RD_LATENCY+1, which never overflows by construction of req_ready_o.
  - rsp_valid_o, rsp_rdata_o, rsp_tag_o and rsp_err_o hold stable while rsp_valid_o && !rsp_ready_i.
- Pointer arithmetic: FIFO pointers wrap modulo depth. Accept and pop in the same cycle leave the outstanding count unchanged.

Optional Feature:
- Macro DMEM_INIT_CLEAR_EN.
- Defined: INIT sweep as above; busy lasts DEPTH_WORDS cycles after reset deasserts.
- Undefined:
  - No sweep; memory contents are undefined after reset.
  - The FSM leaves INIT on the first cycle after reset, so req_ready_o rises one cycle after rst deasserts.
  - busy_o pulses for that one cycle.

Test Plan:
- Reset, then hold rst low.
  - With DMEM_INIT_CLEAR_EN defined and DEPTH_WORDS=16: busy_o=1 for 16 cycles, then req_ready_o=1; LW to 0x3C returns 0x00000000.
  - Without the macro: req_ready_o=1 one cycle after reset.
- SW 0x8040C0FF to 0x10, then LB 0x10 / LBU 0x13 / LH 0x12 / LHU 0x10 / LW 0x10:
  - returns 0xFFFFFFFF, 0x00000080, 0xFFFF8040, 0x0000C0FF, 0x8040C0FF;
  - tags echoed, err=0.
- SB 0xAA to 0x11 over the word 0x8040C0FF: LW 0x10 returns 0x8040AAFF.
- Misaligned and out-of-range cases:
  - SH to 0x21 gives err=1 and memory at 0x20 unchanged.
  - LW to 0x22 gives err=1, rdata=0.
  - With DEPTH_WORDS=16, LW to 0x40 gives err=1.
- RD_LATENCY=3, rsp_ready_i=0, back-to-back loads:
  - exactly 4 accepted, then req_ready_o=0;
  - raising rsp_ready_i drains 4 in-order responses with tags 1..4.
- Assert rst with 2 requests in flight: no response appears after reset, and the INIT sweep restarts.

Source files
------------

// File: rtl/dmem_lsu_bank.sv
// rtl/dmem_lsu_bank.sv - handshaked byte/half/word data-memory bank with in-order tagged responses.
// Define DMEM_INIT_CLEAR_EN to zero every word in a post-reset sweep before accepting requests.
module dmem_lsu_bank #(
    parameter int DATA_WIDTH  = 32,
    parameter int ADDR_WIDTH  = 32,
    parameter int DEPTH_WORDS = 1024,
    parameter int RD_LATENCY  = 1,
    parameter int TAG_WIDTH   = 6
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  req_valid_i,
    output logic                  req_ready_o,
    input  logic                  req_we_i,
    input  logic [ADDR_WIDTH-1:0] req_addr_i,
    input  logic [1:0]            req_size_i,
    input  logic                  req_unsigned_i,
    input  logic [DATA_WIDTH-1:0] req_wdata_i,
    input  logic [TAG_WIDTH-1:0]  req_tag_i,
    output logic                  rsp_valid_o,
    input  logic                  rsp_ready_i,
    output logic [DATA_WIDTH-1:0] rsp_rdata_o,
    output logic [TAG_WIDTH-1:0]  rsp_tag_o,
    output logic                  rsp_err_o,
    output logic                  busy_o
);
    localparam int BYTES  = DATA_WIDTH / 8;
    localparam int OFF_W  = $clog2(BYTES);
    localparam int IDX_W  = $clog2(DEPTH_WORDS);
    localparam int FDEPTH = RD_LATENCY + 1;
    localparam int PTR_W  = $clog2(FDEPTH);
    localparam int CNT_W  = $clog2(FDEPTH + 1);

    typedef enum logic {ST_INIT, ST_RUN} state_t;

    // age counts down to zero; an entry may leave only once its latency has elapsed
    typedef struct packed {
        logic [DATA_WIDTH-1:0] rdata;
        logic [TAG_WIDTH-1:0]  tag;
        logic                  err;
        logic [1:0]            age;
    } entry_t;

    state_t                state_q, state_d;
    logic [DATA_WIDTH-1:0] mem_q [DEPTH_WORDS];
    entry_t                fifo_q [FDEPTH];
    entry_t                fifo_d [FDEPTH];
    logic [PTR_W-1:0]      wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]      rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]      count_q, count_d;
`ifdef DMEM_INIT_CLEAR_EN
    logic [IDX_W-1:0]      init_idx_q, init_idx_d;
`endif

    logic                  accept, pop, req_err;
    logic [IDX_W-1:0]      req_idx;
    int                    off, nbytes;
    logic [BYTES-1:0]      req_be;
    logic [DATA_WIDTH-1:0] req_wrep, rd_shift, load_data, rsp_data;
    logic                  mem_we;
    logic [IDX_W-1:0]      mem_widx;
    logic [DATA_WIDTH-1:0] mem_wdata;
    logic [BYTES-1:0]      mem_be;
    entry_t                head;

    assign head        = fifo_q[rd_ptr_q];
    assign busy_o      = (state_q == ST_INIT);
    assign req_ready_o = (state_q == ST_RUN) && (count_q < CNT_W'(FDEPTH));
    assign accept      = req_valid_i && req_ready_o && !rst;
    assign rsp_valid_o = (count_q != '0) && (head.age == 2'd0);
    assign pop         = rsp_valid_o && rsp_ready_i;
    assign rsp_rdata_o = rsp_valid_o ? head.rdata : '0;
    assign rsp_tag_o   = rsp_valid_o ? head.tag : '0;
    assign rsp_err_o   = rsp_valid_o && head.err;

    always_comb begin
        off     = int'(req_addr_i[OFF_W-1:0]);
        nbytes  = 1 << req_size_i;
        req_idx = req_addr_i[IDX_W+OFF_W-1:OFF_W];
        req_err = (req_size_i == 2'd3)
               || ((req_size_i == 2'd1) && req_addr_i[0])
               || ((req_size_i == 2'd2) && (req_addr_i[1:0] != 2'b00))
               || ((req_addr_i >> (IDX_W + OFF_W)) != '0);
        req_be   = '0;
        req_wrep = '0;
        // aligned accesses make lane modulo size equal to the right-aligned source byte
        for (int b = 0; b < BYTES; b++) begin
            req_be[b]          = (b >= off) && (b < off + nbytes);
            req_wrep[8*b +: 8] = req_wdata_i[8*(b % nbytes) +: 8];
        end
        rd_shift  = mem_q[req_idx] >> (8 * off);
        load_data = '0;
        for (int i = 0; i < DATA_WIDTH; i++) begin
            if (i < 8 * nbytes) begin
                load_data[i] = rd_shift[i];
            end else if (!req_unsigned_i) begin
                load_data[i] = rd_shift[8*nbytes-1];
            end
        end
        rsp_data = (req_we_i || req_err) ? '0 : load_data;
    end

    always_comb begin
        state_d   = state_q;
        mem_we    = 1'b0;
        mem_widx  = req_idx;
        mem_wdata = req_wrep;
        mem_be    = req_be;
`ifdef DMEM_INIT_CLEAR_EN
        init_idx_d = init_idx_q;
`endif
        if (state_q == ST_INIT) begin
`ifdef DMEM_INIT_CLEAR_EN
            mem_we     = !rst;
            mem_widx   = init_idx_q;
            mem_wdata  = '0;
            mem_be     = '1;
            init_idx_d = init_idx_q + 1'b1;
            if (init_idx_q == IDX_W'(DEPTH_WORDS - 1)) begin
                state_d = ST_RUN;
            end
`else
            state_d = ST_RUN;
`endif
        end else begin
            mem_we = accept && req_we_i && !req_err;
        end
    end

    always_comb begin
        fifo_d   = fifo_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        for (int i = 0; i < FDEPTH; i++) begin
            if (fifo_d[i].age != 2'd0) begin
                fifo_d[i].age = fifo_d[i].age - 2'd1;
            end
        end
        if (accept) begin
            fifo_d[wr_ptr_q] = '{rdata: rsp_data, tag: req_tag_i, err: req_err,
                                 age: 2'(RD_LATENCY - 1)};
            wr_ptr_d = (wr_ptr_q == PTR_W'(FDEPTH - 1)) ? '0 : wr_ptr_q + 1'b1;
        end
        if (pop) begin
            rd_ptr_d = (rd_ptr_q == PTR_W'(FDEPTH - 1)) ? '0 : rd_ptr_q + 1'b1;
        end
        if (accept && !pop) begin
            count_d = count_q + 1'b1;
        end else if (!accept && pop) begin
            count_d = count_q - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= ST_INIT;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            for (int i = 0; i < FDEPTH; i++) begin
                fifo_q[i] <= '0;
            end
`ifdef DMEM_INIT_CLEAR_EN
            init_idx_q <= '0;
`endif
        end else begin
            state_q  <= state_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            fifo_q   <= fifo_d;
`ifdef DMEM_INIT_CLEAR_EN
            init_idx_q <= init_idx_d;
`endif
        end
    end

    always_ff @(posedge clk) begin
        if (mem_we) begin
            for (int b = 0; b < BYTES; b++) begin
                if (mem_be[b]) begin
                    mem_q[mem_widx][8*b +: 8] <= mem_wdata[8*b +: 8];
                end
            end
        end
    end

endmodule

// File: tb/tb_dmem_lsu_bank.sv
// tb/tb_dmem_lsu_bank.sv - self-checking bench for dmem_lsu_bank (vector table, corner sequences, random vs model).
module tb_dmem_lsu_bank;
    localparam int L     = 3;
    localparam int DEPTH = 16;
    localparam int NB    = DEPTH * 4;
`ifdef DMEM_INIT_CLEAR_EN
    localparam int EXP_BUSY = DEPTH;
`else
    localparam int EXP_BUSY = 1;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req_valid_i = 1'b0;
    logic        req_ready_o;
    logic        req_we_i = 1'b0;
    logic [31:0] req_addr_i = '0;
    logic [1:0]  req_size_i = '0;
    logic        req_unsigned_i = 1'b0;
    logic [31:0] req_wdata_i = '0;
    logic [5:0]  req_tag_i = '0;
    logic        rsp_valid_o;
    logic        rsp_ready_i = 1'b1;
    logic [31:0] rsp_rdata_o;
    logic [5:0]  rsp_tag_o;
    logic        rsp_err_o;
    logic        busy_o;

    always #5 clk = ~clk;

    dmem_lsu_bank #(
        .DATA_WIDTH(32), .ADDR_WIDTH(32), .DEPTH_WORDS(DEPTH), .RD_LATENCY(L), .TAG_WIDTH(6)
    ) dut (
        .clk(clk), .rst(rst),
        .req_valid_i(req_valid_i), .req_ready_o(req_ready_o), .req_we_i(req_we_i),
        .req_addr_i(req_addr_i), .req_size_i(req_size_i), .req_unsigned_i(req_unsigned_i),
        .req_wdata_i(req_wdata_i), .req_tag_i(req_tag_i),
        .rsp_valid_o(rsp_valid_o), .rsp_ready_i(rsp_ready_i), .rsp_rdata_o(rsp_rdata_o),
        .rsp_tag_o(rsp_tag_o), .rsp_err_o(rsp_err_o), .busy_o(busy_o)
    );

    typedef struct {
        string       name;
        logic        we;
        logic [31:0] addr;
        logic [1:0]  size;
        logic        uns;
        logic [31:0] wdata;
        logic [5:0]  tag;
        logic [31:0] exp_rdata;
        logic        exp_err;
    } vec_t;

    typedef struct {
        logic [31:0] rdata;
        logic [5:0]  tag;
        logic        err;
        int          due;
    } exp_t;

    int         vec_cnt = 0;
    int         err_cnt = 0;
    int         cyc = 0;
    logic [7:0] mm [NB];
    exp_t       q [$];
    vec_t       tbl [$];

    task automatic chk_b(input string name, input logic act, input logic exp);
        vec_cnt++;
        if (act !== exp) begin
            err_cnt++;
            $display("FAIL %s: got %b, expected %b", name, act, exp);
        end
    endtask

    task automatic chk_w(input string name, input logic [31:0] act, input logic [31:0] exp);
        vec_cnt++;
        if (act !== exp) begin
            err_cnt++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    function automatic vec_t mk(input string name, input logic we, input logic [31:0] addr,
                                input logic [1:0] size, input logic uns, input logic [31:0] wdata,
                                input logic [5:0] tag, input logic [31:0] er, input logic ee);
        vec_t v;
        v.name = name; v.we = we; v.addr = addr; v.size = size; v.uns = uns;
        v.wdata = wdata; v.tag = tag; v.exp_rdata = er; v.exp_err = ee;
        return v;
    endfunction

    // Reference: a byte-addressed little-endian memory; accesses are whole byte ranges.
    function automatic exp_t model_req(input logic we, input logic [31:0] addr, input logic [1:0] size,
                                       input logic uns, input logic [31:0] wd, input logic [5:0] tag);
        exp_t        e;
        int          nb;
        logic [31:0] val;
        nb      = 1 << size;
        e.tag   = tag;
        e.rdata = '0;
        e.due   = 0;
        e.err   = (size == 2'd3) || ((addr % nb) != 0) || (addr >= NB);
        if (!e.err) begin
            if (we) begin
                for (int i = 0; i < nb; i++) mm[int'(addr) + i] = wd[8*i +: 8];
            end else begin
                val = '0;
                for (int i = 0; i < nb; i++) val[8*i +: 8] = mm[int'(addr) + i];
                if (!uns && nb < 4 && val[8*nb-1]) begin
                    for (int i = 8 * nb; i < 32; i++) val[i] = 1'b1;
                end
                e.rdata = val;
            end
        end
        return e;
    endfunction

    task automatic model_cycle(input logic v, input logic we, input logic [31:0] addr,
                               input logic [1:0] size, input logic uns, input logic [31:0] wd,
                               input logic [5:0] tag, input logic rr, output logic acc);
        logic exp_valid, exp_ready;
        exp_t e;
        exp_valid = (q.size() > 0) && (q[0].due <= cyc);
        chk_b("rnd_rsp_valid", rsp_valid_o, exp_valid);
        if (exp_valid) begin
            chk_w("rnd_rdata", rsp_rdata_o, q[0].rdata);
            chk_w("rnd_tag", 32'(rsp_tag_o), 32'(q[0].tag));
            chk_b("rnd_err", rsp_err_o, q[0].err);
        end
        exp_ready = (q.size() < L + 1);
        chk_b("rnd_req_ready", req_ready_o, exp_ready);
        req_valid_i = v; req_we_i = we; req_addr_i = addr; req_size_i = size;
        req_unsigned_i = uns; req_wdata_i = wd; req_tag_i = tag; rsp_ready_i = rr;
        acc = v && exp_ready;
        step();
        if (exp_valid && rr) void'(q.pop_front());
        if (acc) begin
            e = model_req(we, addr, size, uns, wd, tag);
            e.due = cyc + L - 1;
            q.push_back(e);
        end
    endtask

    task automatic txn(input vec_t v);
        int n;
        n = 0;
        while (!req_ready_o && n < 50) begin
            step();
            n++;
        end
        chk_b({v.name, "_ready"}, req_ready_o, 1'b1);
        req_we_i = v.we; req_addr_i = v.addr; req_size_i = v.size; req_unsigned_i = v.uns;
        req_wdata_i = v.wdata; req_tag_i = v.tag; req_valid_i = 1'b1;
        step();
        req_valid_i = 1'b0;
        for (int k = 1; k < L; k++) begin
            chk_b({v.name, "_early"}, rsp_valid_o, 1'b0);
            step();
        end
        chk_b({v.name, "_valid"}, rsp_valid_o, 1'b1);
        chk_w({v.name, "_rdata"}, rsp_rdata_o, v.exp_rdata);
        chk_w({v.name, "_tag"}, 32'(rsp_tag_o), 32'(v.tag));
        chk_b({v.name, "_err"}, rsp_err_o, v.exp_err);
        step();
        chk_b({v.name, "_popped"}, rsp_valid_o, 1'b0);
    endtask

    task automatic do_reset();
        int n;
        req_valid_i = 1'b0;
        rst = 1'b1;
        step();
        step();
        chk_b("rst_req_ready", req_ready_o, 1'b0);
        chk_b("rst_rsp_valid", rsp_valid_o, 1'b0);
        chk_w("rst_rsp_rdata", rsp_rdata_o, 32'h0);
        chk_w("rst_rsp_tag", 32'(rsp_tag_o), 32'h0);
        chk_b("rst_rsp_err", rsp_err_o, 1'b0);
        chk_b("rst_busy", busy_o, 1'b1);
        rst = 1'b0;
        n = 0;
        while (busy_o && n < 100) begin
            chk_b("init_ready_low", req_ready_o, 1'b0);
            chk_b("init_no_rsp", rsp_valid_o, 1'b0);
            n++;
            step();
        end
        chk_w("busy_cycles", n, EXP_BUSY);
        chk_b("ready_after_init", req_ready_o, 1'b1);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic        acc;
        int          n, n_acc, r;
        logic [31:0] addr;
        logic [1:0]  size;

        tbl.push_back(mk("sw_10",      1'b1, 32'h10, 2'd2, 1'b0, 32'h8040C0FF, 6'd1,  32'h0,        1'b0));
        tbl.push_back(mk("lb_10",      1'b0, 32'h10, 2'd0, 1'b0, 32'h0,        6'd2,  32'hFFFFFFFF, 1'b0));
        tbl.push_back(mk("lbu_13",     1'b0, 32'h13, 2'd0, 1'b1, 32'h0,        6'd3,  32'h00000080, 1'b0));
        tbl.push_back(mk("lh_12",      1'b0, 32'h12, 2'd1, 1'b0, 32'h0,        6'd4,  32'hFFFF8040, 1'b0));
        tbl.push_back(mk("lhu_10",     1'b0, 32'h10, 2'd1, 1'b1, 32'h0,        6'd5,  32'h0000C0FF, 1'b0));
        tbl.push_back(mk("lw_10",      1'b0, 32'h10, 2'd2, 1'b0, 32'h0,        6'd6,  32'h8040C0FF, 1'b0));
        tbl.push_back(mk("sb_11",      1'b1, 32'h11, 2'd0, 1'b0, 32'h123456AA, 6'd7,  32'h0,        1'b0));
        tbl.push_back(mk("lw_10_sb",   1'b0, 32'h10, 2'd2, 1'b0, 32'h0,        6'd8,  32'h8040AAFF, 1'b0));
        tbl.push_back(mk("sw_20",      1'b1, 32'h20, 2'd2, 1'b0, 32'h12345678, 6'd9,  32'h0,        1'b0));
        tbl.push_back(mk("sh_21_mis",  1'b1, 32'h21, 2'd1, 1'b0, 32'hDEADBEEF, 6'd10, 32'h0,        1'b1));
        tbl.push_back(mk("lw_20",      1'b0, 32'h20, 2'd2, 1'b0, 32'h0,        6'd11, 32'h12345678, 1'b0));
        tbl.push_back(mk("lw_22_mis",  1'b0, 32'h22, 2'd2, 1'b0, 32'h0,        6'd12, 32'h0,        1'b1));
        tbl.push_back(mk("lw_40_oor",  1'b0, 32'h40, 2'd2, 1'b0, 32'h0,        6'd13, 32'h0,        1'b1));
        tbl.push_back(mk("lw_high",    1'b0, 32'h80000010, 2'd2, 1'b0, 32'h0,  6'd14, 32'h0,        1'b1));
        tbl.push_back(mk("size3",      1'b0, 32'h24, 2'd3, 1'b0, 32'h0,        6'd15, 32'h0,        1'b1));
        tbl.push_back(mk("sh_22",      1'b1, 32'h22, 2'd1, 1'b0, 32'hDEADBEEF, 6'd16, 32'h0,        1'b0));
        tbl.push_back(mk("lw_20_sh",   1'b0, 32'h20, 2'd2, 1'b0, 32'h0,        6'd17, 32'hBEEF5678, 1'b0));
        tbl.push_back(mk("lh_22_sx",   1'b0, 32'h22, 2'd1, 1'b0, 32'h0,        6'd63, 32'hFFFFBEEF, 1'b0));

        do_reset();
`ifdef DMEM_INIT_CLEAR_EN
        txn(mk("lw_3c_cleared", 1'b0, 32'h3C, 2'd2, 1'b0, 32'h0, 6'd33, 32'h0, 1'b0));
`endif
        for (int i = 0; i < tbl.size(); i++) txn(tbl[i]);

        // Backpressure: responses pile up until outstanding reaches RD_LATENCY+1.
        rsp_ready_i = 1'b0;
        req_we_i = 1'b0; req_addr_i = 32'h10; req_size_i = 2'd2; req_unsigned_i = 1'b0;
        req_valid_i = 1'b1;
        n_acc = 0;
        for (int k = 0; k < 8; k++) begin
            req_tag_i = 6'(n_acc + 1);
            if (req_ready_o) n_acc++;
            step();
        end
        req_valid_i = 1'b0;
        chk_w("bp_accepted", n_acc, 32'd4);
        chk_b("bp_ready_low", req_ready_o, 1'b0);
        chk_b("bp_rsp_valid", rsp_valid_o, 1'b1);
        step();
        step();
        chk_b("bp_hold_valid", rsp_valid_o, 1'b1);
        chk_w("bp_hold_tag", 32'(rsp_tag_o), 32'd1);
        chk_w("bp_hold_rdata", rsp_rdata_o, 32'h8040AAFF);
        chk_b("bp_hold_ready", req_ready_o, 1'b0);
        rsp_ready_i = 1'b1;
        for (int t = 1; t <= 4; t++) begin
            n = 0;
            while (!rsp_valid_o && n < 10) begin
                step();
                n++;
            end
            chk_b("bp_drain_valid", rsp_valid_o, 1'b1);
            chk_w("bp_drain_tag", 32'(rsp_tag_o), 32'(t));
            chk_w("bp_drain_rdata", rsp_rdata_o, 32'h8040AAFF);
            chk_b("bp_drain_err", rsp_err_o, 1'b0);
            step();
        end
        chk_b("bp_empty", rsp_valid_o, 1'b0);
        chk_b("bp_ready_back", req_ready_o, 1'b1);

        // Reset with two loads in flight: they must vanish and the init phase restarts.
        req_we_i = 1'b0; req_addr_i = 32'h10; req_size_i = 2'd2; req_valid_i = 1'b1;
        req_tag_i = 6'd40;
        step();
        req_tag_i = 6'd41;
        step();
        req_valid_i = 1'b0;
        chk_b("inflight_not_yet", rsp_valid_o, 1'b0);
        do_reset();
        for (int k = 0; k < 6; k++) begin
            chk_b("no_rsp_after_reset", rsp_valid_o, 1'b0);
            step();
        end
`ifdef DMEM_INIT_CLEAR_EN
        txn(mk("lw_10_recleared", 1'b0, 32'h10, 2'd2, 1'b0, 32'h0, 6'd34, 32'h0, 1'b0));
`endif

        // Random phase: fill every word so the model knows all bytes, then mix traffic.
        q.delete();
        for (int w = 0; w < DEPTH; w++) begin
            acc = 1'b0;
            n = 0;
            while (!acc && n < 20) begin
                model_cycle(1'b1, 1'b1, 32'(w * 4), 2'd2, 1'b0, $urandom, 6'(w), 1'b1, acc);
                n++;
            end
            chk_b("fill_accepted", acc, 1'b1);
        end
        for (int k = 0; k < 600; k++) begin
            r    = $urandom_range(0, 99);
            size = ($urandom_range(0, 9) == 0) ? 2'd3 : 2'($urandom_range(0, 2));
            if (r < 8)       addr = 32'h40 + $urandom_range(0, 63);
            else if (r < 10) addr = 32'h80000000 | $urandom_range(0, 63);
            else             addr = $urandom_range(0, NB - 1);
            if (size != 2'd3 && $urandom_range(0, 3) != 0) addr = addr & ~((32'd1 << size) - 32'd1);
            model_cycle($urandom_range(0, 9) < 7, 1'($urandom_range(0, 1)), addr, size,
                        1'($urandom_range(0, 1)), $urandom, 6'($urandom), $urandom_range(0, 9) < 7, acc);
        end
        n = 0;
        while (q.size() > 0 && n < 50) begin
            model_cycle(1'b0, 1'b0, 32'h0, 2'd2, 1'b0, 32'h0, 6'd0, 1'b1, acc);
            n++;
        end
        chk_w("drain_left", 32'(q.size()), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end

endmodule
